// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response and data-bus signal bundle for lsu_ctrl
// Ports (all signals, grouped by side):
//   core : req_valid, req_ready, req_we, req_func3, req_addr, req_wdata,
//          rsp_valid, rsp_rdata, rsp_err
//   bus  : bus_req, bus_gnt, bus_we, bus_addr, bus_be, bus_wdata,
//          bus_rvalid, bus_rdata
// slave modport is the load/store unit, master modport is its environment.
interface lsu_ctrl_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_gnt;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W/8-1:0] bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;
  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between core and a req/gnt/rvalid data bus
// Ports: clk, rst_n (async active-low), io (lsu_ctrl_if.slave: core handshake,
//   response, and bus request/grant/response signals).
// Optional feature: define LSU_MISALIGN_EN to complete misaligned accesses
//   (crossing ones in two beats); otherwise misaligned accesses return rsp_err.
module lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_ctrl_if.slave io
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;
  state_t state;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0] c_f3;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [OW-1:0] c_off;
  logic [3:0] sz_b;
  logic illegal, bad;
  logic [NB-1:0] be_lo;
  logic [DATA_W-1:0] wd_lo, raw, mask, ld;
  logic sgn;
`ifdef LSU_MISALIGN_EN
  logic [DATA_W-1:0] lo_q, wd_hi;
  logic [NB-1:0] be_hi;
  logic cross;
`else
  logic misal;
`endif
  // In IDLE the beat fields come straight from the request so they can be
  // registered on acceptance; afterwards they come from the captured copy.
  always_comb begin
    c_f3 = state == IDLE ? io.req_func3 : f3_q;
    c_addr = state == IDLE ? io.req_addr : addr_q;
    c_wdata = state == IDLE ? io.req_wdata : wdata_q;
    c_off = c_addr[OW-1:0];
    sz_b = 4'd1 << c_f3[1:0];
    illegal = c_f3 == 3'b111 || (DATA_W == 32 && (c_f3 == 3'b011 || c_f3 == 3'b110));
    be_lo = ~({NB{1'b1}} << sz_b) << c_off;
    wd_lo = c_wdata << {c_off, 3'b000};
`ifdef LSU_MISALIGN_EN
    cross = int'(c_off) + int'(sz_b) > NB;
    be_hi = ~({NB{1'b1}} << sz_b) >> (NB - int'(c_off));
    wd_hi = c_wdata >> (DATA_W - 8 * int'(c_off));
    bad = illegal;
    raw = state == WAIT2 ? (lo_q >> {c_off, 3'b000}) | (io.bus_rdata << (DATA_W - 8 * int'(c_off)))
                         : io.bus_rdata >> {c_off, 3'b000};
`else
    misal = |(c_off & OW'(sz_b - 4'd1));
    bad = illegal | misal;
    raw = io.bus_rdata >> {c_off, 3'b000};
`endif
    // mask covers the access width; its top bit picks the sign bit of raw
    mask = ~({DATA_W{1'b1}} << {sz_b, 3'b000});
    sgn = ~c_f3[2] & |(raw & (mask ^ (mask >> 1)));
    ld = (raw & mask) | ({DATA_W{sgn}} & ~mask);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      io.req_ready <= 1'b1;
      io.rsp_valid <= 1'b0;
      io.rsp_rdata <= '0;
      io.rsp_err <= 1'b0;
      io.bus_req <= 1'b0;
      io.bus_we <= 1'b0;
      io.bus_addr <= '0;
      io.bus_be <= '0;
      io.bus_wdata <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
`ifdef LSU_MISALIGN_EN
      lo_q <= '0;
`endif
    end else begin
      io.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (io.req_valid) begin
          we_q <= io.req_we;
          f3_q <= io.req_func3;
          addr_q <= io.req_addr;
          wdata_q <= io.req_wdata;
          io.req_ready <= 1'b0;
          if (bad) begin
            state <= RESP;
            io.rsp_valid <= 1'b1;
            io.rsp_err <= 1'b1;
            io.rsp_rdata <= '0;
          end else begin
            state <= REQ1;
            io.bus_req <= 1'b1;
            io.bus_we <= io.req_we;
            io.bus_addr <= {io.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            io.bus_be <= be_lo;
            io.bus_wdata <= wd_lo;
          end
        end
        REQ1: if (io.bus_gnt) begin
          io.bus_req <= 1'b0;
          state <= WAIT1;
        end
        WAIT1: if (io.bus_rvalid) begin
`ifdef LSU_MISALIGN_EN
          lo_q <= io.bus_rdata;
          if (cross) begin
            state <= REQ2;
            io.bus_req <= 1'b1;
            io.bus_addr <= io.bus_addr + ADDR_W'(NB);
            io.bus_be <= be_hi;
            io.bus_wdata <= wd_hi;
          end else
`endif
          begin
            state <= RESP;
            io.rsp_valid <= 1'b1;
            io.rsp_err <= 1'b0;
            io.rsp_rdata <= we_q ? '0 : ld;
          end
        end
`ifdef LSU_MISALIGN_EN
        REQ2: if (io.bus_gnt) begin
          io.bus_req <= 1'b0;
          state <= WAIT2;
        end
        WAIT2: if (io.bus_rvalid) begin
          state <= RESP;
          io.rsp_valid <= 1'b1;
          io.rsp_err <= 1'b0;
          io.rsp_rdata <= we_q ? '0 : ld;
        end
`endif
        RESP: begin
          state <= IDLE;
          io.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl at DATA_W=32
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) io();
  lsu_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;
  rsp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    rsp_t e;
    if (io.rsp_valid) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_rsp: got rsp_valid expected no response");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_err", io.rsp_err, e.err);
        chk("rsp_rdata", io.rsp_rdata, e.rdata);
      end
    end
  end
  task automatic issue(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                       logic err, logic [31:0] rd, logic push);
    @(negedge clk);
    chk("req_ready_idle", io.req_ready, 1);
    io.req_valid = 1'b1;
    io.req_we = we;
    io.req_func3 = f3;
    io.req_addr = a;
    io.req_wdata = wd;
    if (push) q.push_back('{err, rd});
    @(posedge clk);
    #1 io.req_valid = 1'b0;
  endtask
  task automatic beat(logic [31:0] a, logic [3:0] be, logic [31:0] wd, logic we,
                      logic [31:0] rd, int gdly);
    int k = 0;
    @(negedge clk);
    while (!io.bus_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("bus_req", io.bus_req, 1);
    chk("bus_addr", io.bus_addr, a);
    chk("bus_be", io.bus_be, be);
    chk("bus_wdata", io.bus_wdata, wd);
    chk("bus_we", io.bus_we, we);
    repeat (gdly) begin
      @(negedge clk);
      chk("hold_req", io.bus_req, 1);
      chk("hold_addr", io.bus_addr, a);
      chk("hold_be", io.bus_be, be);
      chk("hold_wdata", io.bus_wdata, wd);
      chk("hold_ready", io.req_ready, 0);
    end
    io.bus_gnt = 1'b1;
    @(posedge clk);
    #1 io.bus_gnt = 1'b0;
    io.bus_rvalid = 1'b1;
    io.bus_rdata = rd;
    @(posedge clk);
    #1 io.bus_rvalid = 1'b0;
  endtask
  task automatic wait_rsp;
    int k = 0;
    while (q.size() != 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rsp_timeout", q.size(), 0);
  endtask
  task automatic no_bus(logic [2:0] f3, logic [31:0] a);
    issue(1'b0, f3, a, 32'h0, 1'b1, 32'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_bus_req", io.bus_req, 0);
    end
    wait_rsp();
  endtask
  initial begin
    io.req_valid = 1'b0;
    io.req_we = 1'b0;
    io.req_func3 = 3'b000;
    io.req_addr = 32'h0;
    io.req_wdata = 32'h0;
    io.bus_gnt = 1'b0;
    io.bus_rvalid = 1'b0;
    io.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", io.req_ready, 1);
    chk("rst_rsp_valid", io.rsp_valid, 0);
    chk("rst_rsp_rdata", io.rsp_rdata, 0);
    chk("rst_rsp_err", io.rsp_err, 0);
    chk("rst_bus_req", io.bus_req, 0);
    chk("rst_bus_we", io.bus_we, 0);
    chk("rst_bus_addr", io.bus_addr, 0);
    chk("rst_bus_be", io.bus_be, 0);
    chk("rst_bus_wdata", io.bus_wdata, 0);
    rst_n = 1'b1;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    beat(32'h100, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0, 0);
    wait_rsp();
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1);
    beat(32'h100, 4'b1000, 32'h0, 1'b0, 32'h80FF0000, 0);
    wait_rsp();
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h00000080, 1'b1);
    beat(32'h100, 4'b1000, 32'h0, 1'b0, 32'h80FF0000, 0);
    wait_rsp();
    issue(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b0, 32'h0, 1'b1);
    beat(32'h100, 4'b1100, 32'hABCD0000, 1'b1, 32'h0, 3);
    wait_rsp();
    issue(1'b0, 3'b001, 32'h106, 32'h0, 1'b0, 32'hFFFFFEDC, 1'b1);
    beat(32'h104, 4'b1100, 32'h0, 1'b0, 32'hFEDC0000, 0);
    wait_rsp();
    issue(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h89ABCDEF, 1'b1);
    beat(32'h200, 4'b1111, 32'h0, 1'b0, 32'h89ABCDEF, 1);
    wait_rsp();
`ifdef LSU_MISALIGN_EN
    issue(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 32'h33445566, 1'b1);
    beat(32'h100, 4'b1100, 32'h0, 1'b0, 32'h55667788, 0);
    beat(32'h104, 4'b0011, 32'h0, 1'b0, 32'h11223344, 0);
    wait_rsp();
    issue(1'b0, 3'b001, 32'h101, 32'h0, 1'b0, 32'hFFFFABCD, 1'b1);
    beat(32'h100, 4'b0110, 32'h0, 1'b0, 32'h00ABCD00, 0);
    wait_rsp();
`else
    no_bus(3'b010, 32'h102);
    no_bus(3'b001, 32'h101);
`endif
    no_bus(3'b011, 32'h100);
    no_bus(3'b111, 32'h100);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mid_bus_req", io.bus_req, 1);
    io.bus_gnt = 1'b1;
    @(posedge clk);
    #1 io.bus_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_bus_req", io.bus_req, 0);
    chk("arst_req_ready", io.req_ready, 1);
    chk("arst_bus_be", io.bus_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    io.bus_rvalid = 1'b1;
    io.bus_rdata = 32'hAAAA5555;
    @(posedge clk);
    #1 io.bus_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rsp_valid", io.rsp_valid, 0);
      chk("late_bus_req", io.bus_req, 0);
      chk("late_req_ready", io.req_ready, 1);
    end
    issue(1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 32'h01020304, 1'b1);
    beat(32'h300, 4'b1111, 32'h0, 1'b0, 32'h01020304, 0);
    wait_rsp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
